// File: rtl/drive_cmd_scheduler_pkg.sv
// Shared types and constants for the drive command scheduler:
// FSM state encoding, command byte classes, nibble codes and the stop byte.
package drive_cmd_scheduler_pkg;

   localparam int unsigned DIST_W = 26;
   localparam int unsigned BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_GAP     = 2'd2,
      ST_BLOCKED = 2'd3
   } state_e;

   typedef enum logic [2:0] {
      CLS_FWD,
      CLS_REV,
      CLS_STEER,
      CLS_STOP,
      CLS_INVALID
   } cls_e;

   localparam logic [3:0] NIB_FWD_A = 4'b0111;
   localparam logic [3:0] NIB_FWD_B = 4'b0101;
   localparam logic [3:0] NIB_FWD_C = 4'b0100;
   localparam logic [3:0] NIB_FWD_D = 4'b1111;
   localparam logic [3:0] NIB_REV   = 4'b0110;
   localparam logic [3:0] NIB_STEER = 4'b0011;

   localparam logic [BYTE_W-1:0] STOP_BYTE = 8'h80;

   // Decode a received byte into its command class.
   function automatic cls_e classify(input logic [BYTE_W-1:0] b);
      cls_e c;
      case (b[7:4])
         NIB_FWD_A, NIB_FWD_B, NIB_FWD_C, NIB_FWD_D: c = CLS_FWD;
         NIB_REV:   c = CLS_REV;
         NIB_STEER: c = CLS_STEER;
         default:   c = (b == STOP_BYTE) ? CLS_STOP : CLS_INVALID;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/cmd_watchdog.sv
// Loadable down-counter with enable and a single expiry pulse per load.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   load_i       : restart the count from load_val_i (also re-arms expiry)
//   load_val_i   : value loaded on load_i
//   en_i         : count enable
//   expire_c_o   : combinational, high for one enabled cycle once the count hits 0
module cmd_watchdog #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             en_i,
   output logic             expire_c_o
);

   logic [CNT_W-1:0] cnt_q;
   logic             armed_q;

   // Count down while enabled; disarm after the expiry cycle so it fires once.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         armed_q <= 1'b0;
      end else if (load_i) begin
         cnt_q   <= load_val_i;
         armed_q <= 1'b1;
      end else if (en_i) begin
         if (cnt_q == '0) begin
            armed_q <= 1'b0;
         end else begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
      end
   end

   assign expire_c_o = en_i && armed_q && (cnt_q == '0);

endmodule

// File: rtl/drive_cmd_scheduler.sv
// Safety/sequencing front-end between the UART receiver and the PWM decision
// block: validates command bytes, inserts a stop dwell on direction reversal,
// blocks motion toward a close obstacle and stops on link silence.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   rx_data, rx_valid   : received byte and its one-cycle strobe
//   distance1/2         : front / rear ranger distance (0 = no echo)
//   cmd_data, cmd_strobe: command byte to PWM block and its load pulse
//   state, blocked      : FSM state and BLOCKED indicator
//   timeout_pulse       : one-cycle pulse when the link watchdog fires
//   reject_cnt          : saturating count of dropped bytes
module drive_cmd_scheduler
   import drive_cmd_scheduler_pkg::*;
#(
   parameter int unsigned       TIMEOUT_CYC = 12_000_000,
   parameter int unsigned       GAP_CYC     = 2_400_000,
   parameter logic [DIST_W-1:0] SAFE_DIST   = 26'd42_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BYTE_W-1:0] rx_data,
   input  logic              rx_valid,
   input  logic [DIST_W-1:0] distance1,
   input  logic [DIST_W-1:0] distance2,
   output logic [BYTE_W-1:0] cmd_data,
   output logic              cmd_strobe,
   output logic [1:0]        state,
   output logic              blocked,
   output logic              timeout_pulse,
   output logic [7:0]        reject_cnt
);

   localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   state_e            state_q, state_d;
   logic [BYTE_W-1:0] cmd_q, cmd_d;
   logic [BYTE_W-1:0] pend_q, pend_d;
   logic [7:0]        rej_q, rej_d;
   logic              dir_rev_q, dir_rev_d;
   logic              strobe_q, strobe_d;
   logic              tmo_q, tmo_d;
   logic              blk_q;
   logic              reject_c;
   logic              pend_rev_c;

   cls_e cls_c;
   logic obs_front_c, obs_rear_c;
   logic mot_c, byte_rev_c, byte_blk_c, cur_blk_c;
   logic link_expire_c, link_exp_c, gap_exp_c, gap_start_c;

   // Input decode: byte class and obstacle tests (0 means no echo).
   assign cls_c       = classify(rx_data);
   assign obs_front_c = (distance1 != '0) && (distance1 < SAFE_DIST);
   assign obs_rear_c  = (distance2 != '0) && (distance2 < SAFE_DIST);
   assign mot_c       = rx_valid && ((cls_c == CLS_FWD) || (cls_c == CLS_REV));
   assign byte_rev_c  = (cls_c == CLS_REV);
   assign byte_blk_c  = mot_c && (byte_rev_c ? obs_rear_c : obs_front_c);
   assign cur_blk_c   = dir_rev_q ? obs_rear_c : obs_front_c;

   // A safe opposite-direction motion byte in RUN starts the reversal dwell.
   assign gap_start_c = (state_q == ST_RUN) && mot_c && !byte_blk_c
                        && (byte_rev_c != dir_rev_q);

   // A byte arriving on the expiry cycle takes priority over the timeout.
   assign link_exp_c = link_expire_c && !rx_valid;

   cmd_watchdog #(.CNT_W(TMO_W)) u_link_wd (
      .clk        (clk),
      .rst        (rst),
      .load_i     (rx_valid),
      .load_val_i (TMO_W'(TIMEOUT_CYC - 1)),
      .en_i       (state_q != ST_IDLE),
      .expire_c_o (link_expire_c)
   );

   cmd_watchdog #(.CNT_W(GAP_W)) u_gap_wd (
      .clk        (clk),
      .rst        (rst),
      .load_i     (gap_start_c),
      .load_val_i (GAP_W'(GAP_CYC - 1)),
      .en_i       (state_q == ST_GAP),
      .expire_c_o (gap_exp_c)
   );

   // Next-state and output decision.
   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      pend_d     = pend_q;
      dir_rev_d  = dir_rev_q;
      strobe_d   = 1'b0;
      tmo_d      = 1'b0;
      reject_c   = 1'b0;
      pend_rev_c = 1'b0;

      if (link_exp_c) begin
         state_d  = ST_IDLE;
         cmd_d    = STOP_BYTE;
         strobe_d = 1'b1;
         tmo_d    = 1'b1;
         pend_d   = STOP_BYTE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (rx_valid) begin
                  if ((cls_c == CLS_INVALID) || byte_blk_c) begin
                     reject_c = 1'b1;
                  end else if (mot_c) begin
                     state_d   = ST_RUN;
                     cmd_d     = rx_data;
                     dir_rev_d = byte_rev_c;
                     strobe_d  = 1'b1;
                  end else if (cls_c == CLS_STEER) begin
                     cmd_d    = rx_data;
                     strobe_d = 1'b1;
                  end else begin
                     cmd_d    = STOP_BYTE;
                     strobe_d = 1'b1;
                  end
               end
            end

            ST_RUN: begin
               if (rx_valid && (cls_c == CLS_STOP)) begin
                  state_d  = ST_IDLE;
                  cmd_d    = STOP_BYTE;
                  strobe_d = 1'b1;
               end else if (gap_start_c) begin
                  state_d  = ST_GAP;
                  cmd_d    = STOP_BYTE;
                  pend_d   = rx_data;
                  strobe_d = 1'b1;
               end else begin
                  if (rx_valid && ((cls_c == CLS_INVALID) || byte_blk_c)) begin
                     reject_c = 1'b1;
                  end
                  // Obstacle in the travel direction overrides any same-cycle byte.
                  if (cur_blk_c) begin
                     state_d  = ST_BLOCKED;
                     cmd_d    = STOP_BYTE;
                     strobe_d = 1'b1;
                  end else if (rx_valid && ((cls_c == CLS_STEER) || (mot_c && !byte_blk_c))) begin
                     cmd_d    = rx_data;
                     strobe_d = 1'b1;
                     if (mot_c) begin
                        dir_rev_d = byte_rev_c;
                     end
                  end
               end
            end

            ST_GAP: begin
               if (rx_valid && ((cls_c == CLS_STEER) || (cls_c == CLS_STOP))) begin
                  state_d  = ST_IDLE;
                  pend_d   = STOP_BYTE;
                  cmd_d    = (cls_c == CLS_STEER) ? rx_data : STOP_BYTE;
                  strobe_d = 1'b1;
               end else begin
                  if (rx_valid && ((cls_c == CLS_INVALID) || byte_blk_c)) begin
                     reject_c = 1'b1;
                  end else if (mot_c) begin
                     pend_d = rx_data;
                  end
                  // Dwell over: release the (possibly just replaced) pending byte.
                  if (gap_exp_c) begin
                     pend_rev_c = (classify(pend_d) == CLS_REV);
                     dir_rev_d  = pend_rev_c;
                     strobe_d   = 1'b1;
                     if (pend_rev_c ? obs_rear_c : obs_front_c) begin
                        state_d = ST_BLOCKED;
                        cmd_d   = STOP_BYTE;
                     end else begin
                        state_d = ST_RUN;
                        cmd_d   = pend_d;
                     end
                     pend_d = STOP_BYTE;
                  end
               end
            end

            ST_BLOCKED: begin
               if (rx_valid) begin
                  if ((cls_c == CLS_INVALID) || byte_blk_c) begin
                     reject_c = 1'b1;
                  end else if (mot_c) begin
                     state_d   = ST_RUN;
                     cmd_d     = rx_data;
                     dir_rev_d = byte_rev_c;
                     strobe_d  = 1'b1;
                  end else if (cls_c == CLS_STEER) begin
                     cmd_d    = rx_data;
                     strobe_d = 1'b1;
                  end else begin
                     state_d  = ST_IDLE;
                     cmd_d    = STOP_BYTE;
                     strobe_d = 1'b1;
                  end
               end
            end
         endcase
      end
   end

   // Saturating reject counter.
   always_comb begin
      rej_d = rej_q;
      if (reject_c && (rej_q != 8'hFF)) begin
         rej_d = rej_q + 8'd1;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cmd_q     <= STOP_BYTE;
         pend_q    <= STOP_BYTE;
         rej_q     <= 8'd0;
         dir_rev_q <= 1'b0;
         strobe_q  <= 1'b0;
         tmo_q     <= 1'b0;
         blk_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         pend_q    <= pend_d;
         rej_q     <= rej_d;
         dir_rev_q <= dir_rev_d;
         strobe_q  <= strobe_d;
         tmo_q     <= tmo_d;
         blk_q     <= (state_d == ST_BLOCKED);
      end
   end

   assign cmd_data      = cmd_q;
   assign cmd_strobe    = strobe_q;
   assign state         = state_q;
   assign blocked       = blk_q;
   assign timeout_pulse = tmo_q;
   assign reject_cnt    = rej_q;

endmodule

// File: doc/drive_cmd_scheduler.md
# drive_cmd_scheduler

Sequencing and safety front-end for the motor/servo PWM decision block. Sits between the UART receiver and the PWM decision block's `rx_data` input. Validates each received command byte and enforces a stop gap on every forward/reverse reversal. It also gates motion toward an obstacle reported by the ultrasonic rangers and forces a stop when the command link goes silent.

## Interface
Parameters:
- `TIMEOUT_CYC`, 12_000_000: link-silence watchdog (0.5 s at 24 MHz).
- `GAP_CYC`, 2_400_000: forced stop dwell on direction reversal (0.1 s).
- `SAFE_DIST`, 26'd42_000: obstacle threshold in ranger count units.

Ports:
- `clk`, in, 1: 24 MHz system clock.
- `rst`, in, 1: synchronous, active-high reset.
- `rx_data`, in, 8: received command byte.
- `rx_valid`, in, 1: one-cycle strobe; `rx_data` is valid this cycle.
- `distance1`, in, 26: front ranger distance.
- `distance2`, in, 26: rear ranger distance.
- `cmd_data`, out, 8: command byte driven to the PWM decision block.
- `cmd_strobe`, out, 1: one-cycle pulse on every `cmd_data` load.
- `state`, out, 2: IDLE=0, RUN=1, GAP=2, BLOCKED=3.
- `blocked`, out, 1: high while in BLOCKED.
- `timeout_pulse`, out, 1: one-cycle pulse when the watchdog fires.
- `reject_cnt`, out, 8: saturating count of dropped bytes.

## Operation
- Byte classes, decoded from `rx_data[7:4]`:
  - FWD: 0111, 0101, 0100, 1111.
  - REV: 0110.
  - STEER: 0011.
  - STOP: exactly 8'h80.
  - Anything else is INVALID: dropped and `reject_cnt`++.
- Obstacle: front = `distance1 != 0 && distance1 < SAFE_DIST`; rear = the same test on `distance2`. A distance of 0 means no echo and never counts as an obstacle.
- IDLE:
  - `cmd_data` = 8'h80.
  - FWD/REV byte → RUN and load the byte, subject to the obstacle gate.
  - STEER → load the byte, stay IDLE.
  - STOP → reload 8'h80.
- RUN:
  - Same-direction FWD/REV, or STEER → load the byte.
  - Opposite direction (last loaded motion byte had the other direction) → GAP. Load 8'h80, store the byte as pending, clear the gap counter.
  - STOP → IDLE, load 8'h80.
- GAP:
  - `cmd_data` is held at 8'h80.
  - A new FWD/REV byte overwrites pending; the gap counter is not restarted.
  - STEER/STOP cancels pending and is processed as if in IDLE.
  - At gap count `GAP_CYC-1`, load pending and go to RUN. The obstacle gate still applies.
- Obstacle gate:
  - In RUN, last direction FWD and front obstacle true → BLOCKED, load 8'h80. REV with rear obstacle behaves the same.
  - A FWD byte arriving while the front obstacle is true is dropped and `reject_cnt`++. REV with rear obstacle is handled the same way.
- BLOCKED:
  - `cmd_data` = 8'h80.
  - Bytes toward the blocked side are rejected.
  - A safe-direction motion byte → RUN and load it (no GAP; the vehicle is already stopped).
  - STEER → load the byte.
  - STOP → IDLE.
  - If the obstacle clears with no new byte, stay BLOCKED.
- Watchdog:
  - The counter clears on any `rx_valid`, including invalid bytes.
  - In RUN, GAP or BLOCKED, reaching `TIMEOUT_CYC-1` with no `rx_valid` → IDLE. Load 8'h80, pulse `timeout_pulse`, drop pending.
  - The watchdog is disabled in IDLE.
- `reject_cnt` saturates at 255 and clears only on reset.

## Timing
- Reset values:
  - `cmd_data` = 8'h80.
  - `state` = IDLE.
  - `cmd_strobe`, `blocked`, `timeout_pulse` = 0.
  - `reject_cnt` = 0.
  - All counters 0, pending empty.
- Latency: an accepted byte appears on `cmd_data` with `cmd_strobe` high on the cycle after `rx_valid`.
- Obstacle-to-stop latency: 1 cycle from the distance input crossing the threshold.
- GAP length: exactly `GAP_CYC` cycles of 8'h80, then pending loads.
- Simultaneous events:
  - `rx_valid` and watchdog expiry in the same cycle: the byte wins, no timeout.
  - `rx_valid` and obstacle in the same cycle: the obstacle wins for the blocked direction.
  - `rx_valid` and gap expiry in the same cycle: the new byte replaces pending, then loads.
- Reset mid-GAP or mid-BLOCKED: returns to reset values on the next edge.

## Structure
- Shared package holds:
  - The state encoding.
  - Byte class enum {FWD, REV, STEER, STOP, INVALID}.
  - Nibble constants 0111/0101/0100/1111/0110/0011.
  - STOP_BYTE = 8'h80.
- Sub-module `cmd_watchdog`: loadable down-counter with clear, enable and one-cycle expiry pulse. It is instantiated twice: once for the link timeout and once for the GAP dwell.

## Test plan
- Reset, then `rx_valid` with 8'h74 → next cycle `cmd_data` = 8'h74, `cmd_strobe` = 1, `state` = RUN.
- RUN with 8'h74, then send 8'h64 → `cmd_data` = 8'h80 for `GAP_CYC` cycles (use a reduced parameter, e.g. 16), then 8'h64.
- RUN with 8'h74, set `distance1` = 1000 → next cycle `cmd_data` = 8'h80, `blocked` = 1. Send 8'h74 → `reject_cnt` = 1. Send 8'h64 → RUN, `cmd_data` = 8'h64.
- RUN with `TIMEOUT_CYC` = 32 and no bytes → on cycle 32, `cmd_data` = 8'h80, `timeout_pulse` = 1, `state` = IDLE. Send 8'h74 at cycle 31 instead → no timeout.
- Send 8'h25 → no `cmd_data` change, `reject_cnt` increments. Send 300 invalid bytes → `reject_cnt` = 255.
- `distance1` = 0 with 8'h74 → no block. Assert `rst` during GAP → `cmd_data` = 8'h80, `state` = IDLE, pending dropped.
